// File: rtl/svfloat_addsub_stream.sv
`default_nettype none
// ============================================================================
// Module   : svfloat_addsub_stream (plus package svfloat)
// Purpose  : Streaming float add/subtract with four runtime operations, a
//            valid/ready handshake on both sides, a bubble-collapsing output
//            pipeline of DEPTH slots and a sideband tag returned with each
//            result.
// Ports    : clk, rst             clock, synchronous active-high reset
//            in_valid/in_ready    input handshake
//            in_op                00 l+r, 01 l-r, 10 r-l, 11 -(l+r)
//            in_lhs/in_rhs/in_tag operands and sideband tag
//            out_valid/out_ready  output handshake
//            out_res/out_tag      result and its tag
//            occupancy            number of valid pipeline slots
// Revision : 1.0 - initial release
// ============================================================================

package svfloat;
    typedef logic [31:0] float32;

    // Sign flip that leaves any NaN untouched.
    function automatic float32 neg(input float32 x);
        if ((&x[30:23]) && (|x[22:0])) return x;
        return {~x[31], x[30:0]};
    endfunction

    // IEEE-754 binary32 add, round-to-nearest-even, canonical quiet NaN.
    function automatic float32 add(input float32 a, input float32 b);
        logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, rnd;
        float32      x, y;
        logic [9:0]  ex, ey, e, sh;
        logic [7:0]  d;
        logic [4:0]  lz;
        logic [55:0] wide;
        logic [27:0] mx, my, s;
        logic [24:0] sig;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return b;
        // x carries the larger magnitude, so its sign is the result sign.
        swap = b[30:0] > a[30:0];
        x    = swap ? b : a;
        y    = swap ? a : b;
        ex   = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey   = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        d    = 8'(ex - ey);
        // 24-bit significand with guard, round and sticky bits below it.
        mx   = {1'b0, |x[30:23], x[22:0], 3'b000};
        wide = {1'b0, |y[30:23], y[22:0], 3'b000, 28'd0} >> ((d > 8'd31) ? 8'd31 : d);
        my   = {wide[55:29], wide[28] | (|wide[27:0])};
        eff_sub = x[31] ^ y[31];
        s    = eff_sub ? (mx - my) : (mx + my);
        if (s == 28'd0) return {~eff_sub & x[31], 31'd0};
        e = ex;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            lz = 5'd0;
            for (int i = 0; i <= 26; i++) begin
                if (s[i]) lz = 5'(26 - i);
            end
            // Stop normalising at the minimum exponent: result is subnormal.
            sh = (10'(lz) > (e - 10'd1)) ? (e - 10'd1) : 10'(lz);
            s  = s << sh;
            e  = e - sh;
        end
        rnd = s[2] && (s[1] || s[0] || s[3]);
        sig = {1'b0, s[26:3]} + {24'd0, rnd};
        if (sig[24]) begin
            sig = sig >> 1;
            e   = e + 10'd1;
        end
        if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], sig[23] ? e[7:0] : 8'd0, sig[22:0]};
    endfunction
endpackage

module svfloat_addsub_stream #(
    parameter type FLOAT = svfloat::float32,
    parameter int  DEPTH = 2,
    parameter int  TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [$bits(FLOAT)-1:0]    in_lhs,
    input  logic [$bits(FLOAT)-1:0]    in_rhs,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$bits(FLOAT)-1:0]    out_res,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int c_occ_w = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("DEPTH must lie in 1..8");
    end
    if (TAG_W < 1 || TAG_W > 32) begin : g_bad_tag_w
        $error("TAG_W must lie in 1..32");
    end
    if ($bits(FLOAT) != 32) begin : g_bad_float
        $error("only the 32-bit float format is supported");
    end

    // Combinational arithmetic core.
    svfloat::float32 w_lhs_n, w_rhs_n, w_sum, w_res;
    assign w_lhs_n = (in_op == 2'b10) ? svfloat::neg(in_lhs) : in_lhs;
    assign w_rhs_n = (in_op == 2'b01) ? svfloat::neg(in_rhs) : in_rhs;
    assign w_sum   = svfloat::add(w_lhs_n, w_rhs_n);
    assign w_res   = (in_op == 2'b11) ? svfloat::neg(w_sum) : w_sum;

    logic [DEPTH-1:0]         r_valid;
    logic [$bits(FLOAT)-1:0]  r_res [DEPTH];
    logic [TAG_W-1:0]         r_tag [DEPTH];
    logic [c_occ_w-1:0]       r_occ;

    logic [DEPTH-1:0]         w_load;
    logic [DEPTH-1:0]         w_next_valid;
    logic [c_occ_w-1:0]       w_occ_next;

    // A slot loads when it is empty or its successor moves on, so beats
    // slide forward into bubbles even while the output is stalled.
    always_comb begin
        w_load       = '0;
        w_next_valid = '0;
        w_occ_next   = '0;
        w_load[DEPTH-1] = ~r_valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_load[i] = ~r_valid[i] | w_load[i+1];
        end
        w_next_valid[0] = w_load[0] ? in_valid : r_valid[0];
        for (int i = 1; i < DEPTH; i++) begin
            w_next_valid[i] = w_load[i] ? r_valid[i-1] : r_valid[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_next = w_occ_next + c_occ_w'(w_next_valid[i]);
        end
    end

    // Payload only moves with a valid beat, so a stalled or drained output
    // keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            r_valid <= w_next_valid;
            r_occ   <= w_occ_next;
            if (w_load[0] && in_valid) begin
                r_res[0] <= w_res;
                r_tag[0] <= in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_load[i] && r_valid[i-1]) begin
                    r_res[i] <= r_res[i-1];
                    r_tag[i] <= r_tag[i-1];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[DEPTH-1];
    assign out_res   = r_res[DEPTH-1];
    assign out_tag   = r_tag[DEPTH-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_svfloat_addsub_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_svfloat_addsub_stream
// Purpose  : Self-checking bench for svfloat_addsub_stream (DEPTH=3). Uses a
//            transaction-level model: a queue of accepted beats with their
//            acceptance cycle, and an exact wide-integer float reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svfloat_addsub_stream;
    localparam int DEPTH = 3;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [1:0]        in_op;
    logic [31:0]       in_lhs, in_rhs, out_res;
    logic [TAG_W-1:0]  in_tag, out_tag;
    logic [1:0]        occupancy;

    always #5 clk = ~clk;

    svfloat_addsub_stream #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .occupancy(occupancy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_drain = -100;
    bit post_rst = 1'b0;
    bit dir_use = 1'b0;
    logic [31:0] dir_exp = 32'd0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc;
    } beat_t;
    beat_t q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_neg(input logic [31:0] x);
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return x;
        return {~x[31], x[30:0]};
    endfunction

    // Exact sum on a wide integer grid, then one RNE rounding step.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, xa, xb, emin, p, e, sh;
        logic [299:0] ma, mb, va, vb, s, qq, rem, half;
        logic sgn;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
        if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        emin = (xa < xb) ? xa : xb;
        ma = {276'd0, (ea != 0), a[22:0]};
        mb = {276'd0, (eb != 0), b[22:0]};
        va = ma << (xa - emin);
        vb = mb << (xb - emin);
        if (a[31] == b[31]) begin s = va + vb; sgn = a[31]; end
        else if (va >= vb)  begin s = va - vb; sgn = a[31]; end
        else                begin s = vb - va; sgn = b[31]; end
        if (s == 0) return {(a[31] == b[31]) ? a[31] : 1'b0, 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (s[i]) p = i;
        e  = emin + p - 23;
        sh = p - 23;
        if (e < 1) begin sh = sh + 1 - e; e = 1; end
        if (sh > 0) begin
            qq   = s >> sh;
            rem  = s & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && qq[0])) qq = qq + 300'd1;
        end else begin
            qq = s << (-sh);
        end
        if (qq[24]) begin qq = qq >> 1; e = e + 1; end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        return {sgn, qq[23] ? 8'(e) : 8'd0, qq[22:0]};
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] l, input logic [31:0] r);
        case (op)
            2'b00:   return ref_add(l, r);
            2'b01:   return ref_add(l, ref_neg(r));
            2'b10:   return ref_add(ref_neg(l), r);
            default: return ref_neg(ref_add(l, r));
        endcase
    endfunction

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        logic [31:0] v;
        int e;
        case ($urandom_range(0, 5))
            0: case ($urandom_range(0, 7))
                   0: v = 32'h0000_0000;  1: v = 32'h8000_0000;
                   2: v = 32'h7F80_0000;  3: v = 32'hFF80_0000;
                   4: v = 32'h7FC0_0000;  5: v = 32'h0000_0001;
                   6: v = 32'h807F_FFFF;  default: v = 32'h7F7F_FFFF;
               endcase
            1, 2: begin
                e = int'(other[30:23]) + int'($urandom_range(0, 4)) - 2;
                if (e < 0) e = 0;
                if (e > 254) e = 254;
                v = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
            end
            3: v = {~other[31], other[30:4], 4'($urandom)};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ---------------- one clock cycle ----------------
    task automatic step(output bit acc);
        bit er, ev;
        beat_t b;
        @(negedge clk);
        er  = (q.size() < DEPTH) || out_ready;
        ev  = (q.size() != 0) && (cyc >= q[0].acc + DEPTH) && (cyc >= last_drain + 1);
        acc = 1'b0;
        if (!rst) begin
            check_val("in_ready", 32'(in_ready), 32'(er));
            check_val("out_valid", 32'(out_valid), 32'(ev));
            check_val("occupancy", 32'(occupancy), 32'(q.size()));
            if (ev) begin
                check_val("out_res", out_res, q[0].res);
                check_val("out_tag", 32'(out_tag), 32'(q[0].tag));
            end
            if (post_rst) begin
                check_val("rst_out_res", out_res, 32'd0);
                check_val("rst_out_tag", 32'(out_tag), 32'd0);
                post_rst = 1'b0;
            end
            if (ev && out_ready) begin
                void'(q.pop_front());
                last_drain = cyc;
            end
            if (in_valid && er) begin
                b.res = dir_use ? dir_exp : ref_op(in_op, in_lhs, in_rhs);
                b.tag = in_tag;
                b.acc = cyc;
                q.push_back(b);
                acc = 1'b1;
            end
        end else begin
            q.delete();
            last_drain = -100;
            post_rst   = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    // Offer a beat and hold it until accepted (bounded).
    task automatic offer(input logic [1:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [TAG_W-1:0] tag, input bit use_exp, input logic [31:0] exp);
        bit acc;
        in_valid = 1'b1; in_op = op; in_lhs = l; in_rhs = r; in_tag = tag;
        dir_use = use_exp; dir_exp = exp;
        for (int i = 0; i < 50; i++) begin
            step(acc);
            if (acc) break;
        end
        dir_use = 1'b0;
    endtask

    logic [31:0] basic_exp [4];

    initial begin
        bit acc;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_lhs = '0; in_rhs = '0;
        in_tag = '0; out_ready = 1'b1;
        basic_exp[0] = 32'h4080_0000; basic_exp[1] = 32'h4000_0000;
        basic_exp[2] = 32'hC000_0000; basic_exp[3] = 32'hC080_0000;
        #1;
        step(acc); step(acc);
        rst = 1'b0;

        // Basic operations, back to back, tags 1..4.
        for (int i = 0; i < 4; i++)
            offer(2'(i), 32'h4040_0000, 32'h3F80_0000, 4'(i + 1), 1'b1, basic_exp[i]);
        idle(DEPTH + 2);

        // NaN preservation and zero signs.
        offer(2'b01, 32'h3F80_0000, 32'h7FC0_0000, 4'd5, 1'b1, 32'h7FC0_0000);
        offer(2'b11, 32'h3F80_0000, 32'h7FC0_0000, 4'd6, 1'b1, 32'h7FC0_0000);
        offer(2'b01, 32'h3F80_0000, 32'h3F80_0000, 4'd7, 1'b1, 32'h0000_0000);
        offer(2'b11, 32'h3F80_0000, 32'hBF80_0000, 4'd8, 1'b1, 32'h8000_0000);
        idle(DEPTH + 2);

        // Backpressure: fill, hold a fourth beat, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            offer(2'b00, 32'h3F80_0000 + 32'(i << 20), 32'h4000_0000, 4'(9 + i), 1'b0, 32'd0);
        in_valid = 1'b1; in_op = 2'b01; in_lhs = 32'h4120_0000; in_rhs = 32'h3F80_0000; in_tag = 4'd12;
        for (int i = 0; i < 4; i++) step(acc);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            offer(2'b01, 32'h4120_0000 + 32'(i << 19), 32'h3F80_0000, 4'(12 + i), 1'b0, 32'd0);
        idle(DEPTH + 3);

        // Bubble collapse behind a stalled output.
        out_ready = 1'b0;
        offer(2'b00, 32'h4000_0000, 32'h4000_0000, 4'd1, 1'b1, 32'h4080_0000);
        idle(10);
        offer(2'b10, 32'h4000_0000, 32'h4100_0000, 4'd2, 1'b1, 32'h40C0_0000);
        idle(5);
        out_ready = 1'b1;
        idle(DEPTH + 2);

        // Reset with three beats in flight and a beat offered during reset.
        for (int i = 0; i < 3; i++)
            offer(2'b00, 32'h3F80_0000, 32'h3F80_0000, 4'(3 + i), 1'b0, 32'd0);
        rst = 1'b1; in_valid = 1'b1; in_tag = 4'd15;
        step(acc);
        rst = 1'b0;
        idle(DEPTH + 3);

        // Randomised traffic with random backpressure.
        acc = 1'b1;
        in_valid = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_op    = 2'($urandom_range(0, 3));
                in_lhs   = rand_fp($urandom);
                in_rhs   = rand_fp(in_lhs);
                in_tag   = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            step(acc);
        end
        out_ready = 1'b1;
        idle(DEPTH + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
